// File: rtl/pen_rr_arbiter.sv
// pen_rr_arbiter: registered round-robin arbiter granting up to N of WIDTH
// requesters per cycle. Selection is LSB-first starting at rr_ptr and wrapping,
// so it behaves as an N-way priority encoder with rotation.
// Optional feature: define PEN_RR_ARB_PERF_EN to add perf_stall_count, a
// saturating count of cycles with valid grants that are not accepted.
module pen_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int N     = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [WIDTH-1:0]             req_vec,
  input  logic                         grant_ready,
  output logic [N-1:0]                 grant_valid_by_n,
  output logic [N-1:0][WIDTH-1:0]      grant_one_hot_by_n,
  output logic [$clog2(WIDTH)-1:0]     rr_ptr
`ifdef PEN_RR_ARB_PERF_EN
  ,
  output logic [31:0]                  perf_stall_count
`endif
);

  localparam int PW = $clog2(WIDTH);

  logic [WIDTH-1:0]        held_mask;
  logic [WIDTH-1:0]        eligible;
  logic                    load;
  logic [N-1:0]            sel_valid;
  logic [N-1:0][WIDTH-1:0] sel_oh;
  logic [PW-1:0]           sel_next_ptr;

  // Requesters already sitting in the output register; their request bit only
  // drops the cycle after acceptance, so they must not be granted twice.
  always_comb begin
    held_mask = '0;
    for (int n = 0; n < N; n++) begin
      held_mask = held_mask | grant_one_hot_by_n[n];
    end
  end

  assign load     = ~|grant_valid_by_n | grant_ready;
  assign eligible = req_vec & ~held_mask;

  // Rank each eligible requester by its distance from rr_ptr in rotated order;
  // rank n goes to slot n. The pointer advances past the furthest granted one.
  always_comb begin : select
    int pos [WIDTH];
    int rank;
    int best_pos;
    sel_valid    = '0;
    sel_oh       = '0;
    sel_next_ptr = rr_ptr;
    best_pos     = -1;
    for (int i = 0; i < WIDTH; i++) begin
      pos[i] = i - int'(rr_ptr);
      if (pos[i] < 0) pos[i] = pos[i] + WIDTH;
    end
    for (int i = 0; i < WIDTH; i++) begin
      rank = 0;
      for (int j = 0; j < WIDTH; j++) begin
        if (eligible[j] && (pos[j] < pos[i])) rank = rank + 1;
      end
      for (int n = 0; n < N; n++) begin
        if (eligible[i] && (rank == n)) begin
          sel_valid[n]    = 1'b1;
          sel_oh[n][i]    = 1'b1;
        end
      end
      if (eligible[i] && (rank < N) && (pos[i] > best_pos)) begin
        best_pos     = pos[i];
        sel_next_ptr = (i == WIDTH - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // Output register: reload on empty or accept, otherwise hold the grants.
  always_ff @(posedge CLK) begin
    if (RST) begin
      grant_valid_by_n   <= '0;
      grant_one_hot_by_n <= '0;
      rr_ptr             <= '0;
    end else if (load) begin
      grant_valid_by_n   <= sel_valid;
      grant_one_hot_by_n <= sel_oh;
      if (|sel_valid) rr_ptr <= sel_next_ptr;
    end
  end

`ifdef PEN_RR_ARB_PERF_EN
  // Saturating count of cycles where valid grants are stalled by the consumer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_stall_count <= '0;
    end else if (|grant_valid_by_n && !grant_ready && (perf_stall_count != 32'hFFFF_FFFF)) begin
      perf_stall_count <= perf_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pen_rr_arbiter.sv
// Bench for pen_rr_arbiter (WIDTH=8, N=3): vector table plus hand-written
// backpressure and mid-operation reset sequences, checked through a queue.
module tb_pen_rr_arbiter;

  localparam int WIDTH = 8;
  localparam int N     = 3;

  logic                    CLK = 1'b0;
  logic                    RST;
  logic [WIDTH-1:0]        req_vec;
  logic                    grant_ready;
  logic [N-1:0]            grant_valid_by_n;
  logic [N-1:0][WIDTH-1:0] grant_one_hot_by_n;
  logic [2:0]              rr_ptr;
`ifdef PEN_RR_ARB_PERF_EN
  logic [31:0]             perf_stall_count;
`endif

  pen_rr_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .req_vec            (req_vec),
    .grant_ready        (grant_ready),
    .grant_valid_by_n   (grant_valid_by_n),
    .grant_one_hot_by_n (grant_one_hot_by_n),
    .rr_ptr             (rr_ptr)
`ifdef PEN_RR_ARB_PERF_EN
    ,
    .perf_stall_count   (perf_stall_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [7:0]  req;
    logic        rdy;
    logic [2:0]  v;
    logic [7:0]  s0;
    logic [7:0]  s1;
    logic [7:0]  s2;
    logic [2:0]  ptr;
    logic [31:0] perf;
  } vec_t;

  vec_t tbl [17];
  vec_t sb  [$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic rst, input logic [7:0] req, input logic rdy,
                              input logic [2:0] v, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [2:0] ptr, input logic [31:0] perf);
    vec_t r;
    r.rst = rst; r.req = req; r.rdy = rdy; r.v = v;
    r.s0 = s0; r.s1 = s1; r.s2 = s2; r.ptr = ptr; r.perf = perf;
    return r;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", name, step, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic drive(input vec_t s, input int step);
    vec_t e;
    RST         = s.rst;
    req_vec     = s.req;
    grant_ready = s.rdy;
    sb.push_back(s);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk("valid", step, 32'(grant_valid_by_n), 32'(e.v));
    chk("slot0", step, 32'(grant_one_hot_by_n[0]), 32'(e.s0));
    chk("slot1", step, 32'(grant_one_hot_by_n[1]), 32'(e.s1));
    chk("slot2", step, 32'(grant_one_hot_by_n[2]), 32'(e.s2));
    chk("rr_ptr", step, 32'(rr_ptr), 32'(e.ptr));
`ifdef PEN_RR_ARB_PERF_EN
    chk("perf", step, perf_stall_count, e.perf);
`endif
  endtask

  initial begin
    RST = 1'b1; req_vec = '0; grant_ready = 1'b1;

    //              rst  req    rdy  v       s0     s1     s2     ptr perf
    tbl[0]  = mk(1, 8'hFF, 1, 3'b000, 8'h00, 8'h00, 8'h00, 3'd0, 0);
    tbl[1]  = mk(1, 8'hFF, 1, 3'b000, 8'h00, 8'h00, 8'h00, 3'd0, 0);
    tbl[2]  = mk(0, 8'h04, 1, 3'b001, 8'h04, 8'h00, 8'h00, 3'd3, 0);
    tbl[3]  = mk(1, 8'h00, 1, 3'b000, 8'h00, 8'h00, 8'h00, 3'd0, 0);
    tbl[4]  = mk(0, 8'hFF, 1, 3'b111, 8'h01, 8'h02, 8'h04, 3'd3, 0);
    tbl[5]  = mk(0, 8'hFF, 1, 3'b111, 8'h08, 8'h10, 8'h20, 3'd6, 0);
    tbl[6]  = mk(0, 8'hFF, 1, 3'b111, 8'h40, 8'h80, 8'h01, 3'd1, 0);
    tbl[7]  = mk(1, 8'h00, 1, 3'b000, 8'h00, 8'h00, 8'h00, 3'd0, 0);
    tbl[8]  = mk(0, 8'h20, 1, 3'b001, 8'h20, 8'h00, 8'h00, 3'd6, 0);
    tbl[9]  = mk(0, 8'h41, 1, 3'b011, 8'h40, 8'h01, 8'h00, 3'd1, 0);
    tbl[10] = mk(0, 8'h00, 1, 3'b000, 8'h00, 8'h00, 8'h00, 3'd1, 0);
    tbl[11] = mk(0, 8'h40, 1, 3'b001, 8'h40, 8'h00, 8'h00, 3'd7, 0);
    tbl[12] = mk(0, 8'h80, 1, 3'b001, 8'h80, 8'h00, 8'h00, 3'd0, 0);
    tbl[13] = mk(0, 8'h00, 1, 3'b000, 8'h00, 8'h00, 8'h00, 3'd0, 0);
    tbl[14] = mk(0, 8'h06, 0, 3'b011, 8'h02, 8'h04, 8'h00, 3'd3, 0);
    tbl[15] = mk(0, 8'hFF, 0, 3'b011, 8'h02, 8'h04, 8'h00, 3'd3, 1);
    tbl[16] = mk(0, 8'hFF, 1, 3'b111, 8'h08, 8'h10, 8'h20, 3'd6, 1);

    foreach (tbl[i]) drive(tbl[i], i);

    // Backpressure: hold {01,02,04} for four stalled cycles while req changes.
    drive(mk(1, 8'h00, 1, 3'b000, 8'h00, 8'h00, 8'h00, 3'd0, 0), 100);
    drive(mk(0, 8'hFF, 1, 3'b111, 8'h01, 8'h02, 8'h04, 3'd3, 0), 101);
    for (int k = 0; k < 4; k++) begin
      drive(mk(0, 8'hF0, 0, 3'b111, 8'h01, 8'h02, 8'h04, 3'd3, 32'(k + 1)), 102 + k);
    end
    drive(mk(0, 8'hF0, 1, 3'b111, 8'h10, 8'h20, 8'h40, 3'd7, 4), 106);

    // Mid-operation reset with grants stalled, then fresh traffic.
    drive(mk(0, 8'hF0, 0, 3'b111, 8'h10, 8'h20, 8'h40, 3'd7, 5), 200);
    drive(mk(1, 8'hF0, 0, 3'b000, 8'h00, 8'h00, 8'h00, 3'd0, 0), 201);
    drive(mk(0, 8'h81, 1, 3'b011, 8'h01, 8'h80, 8'h00, 3'd0, 0), 202);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
